// File: rtl/if_stage_pkg.sv
// Shared widths, reset/bubble constants, FSM encoding and IF/ID payload for the fetch stage.
package if_stage_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [PC_W-1:0]   PC_RESET_ADDR = 16'h0000;
    localparam logic [INST_W-1:0] IF_NOP_INST   = 16'h0800;

    typedef enum logic {
        IF_ST_RUN  = 1'b0,
        IF_ST_PEND = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

    // Word-addressed increment, wraps 0xFFFF -> 0x0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
        return PC_W'(a + PC_W'(1));
    endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: load, hold, or bubble; synchronous active-low reset to a bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = IF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [PC_W-1:0]   i_npc,
    input  logic [INST_W-1:0] i_inst,
    output logic [PC_W-1:0]   o_pc,
    output logic [PC_W-1:0]   o_npc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_valid
);

    if_id_t r_q;
    if_id_t w_bubble_val;

    assign w_bubble_val = '{pc: '0, npc: '0, inst: NOP_INST, valid: 1'b0};

    // Bubble wins over load so a flush always kills the word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= w_bubble_val;
        end else if (i_bubble) begin
            r_q <= w_bubble_val;
        end else if (i_load) begin
            r_q <= '{pc: i_pc, npc: i_npc, inst: i_inst, valid: 1'b1};
        end
    end

    assign o_pc    = r_q.pc;
    assign o_npc   = r_q.npc;
    assign o_inst  = r_q.inst;
    assign o_valid = r_q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, stall/redirect FSM and IF/ID register.
// Optional fetched-instruction counter enabled by defining IF_FETCH_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]   PC_RESET = PC_RESET_ADDR,
    parameter logic [INST_W-1:0] NOP_INST = IF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   id_pc,
    output logic [PC_W-1:0]   id_npc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic [CNT_W-1:0]  fetch_cnt
);

    if_state_e         r_state;
    if_state_e         w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   r_pend_target;
    logic [PC_W-1:0]   w_pend_nxt;
    logic [PC_W-1:0]   w_pc_plus1;
    logic              w_load;
    logic              w_bubble;

    assign w_pc_plus1 = pc_inc(r_pc);

    // State, PC and pending redirect target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IF_ST_RUN;
            r_pc          <= PC_RESET;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_target <= w_pend_nxt;
        end
    end

    // Next-state and IF/ID control; a redirect seen during a stall is parked until release.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_target;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        unique case (r_state)
            IF_ST_RUN: begin
                if (br_taken && stall) begin
                    w_pend_nxt  = br_target;
                    w_state_nxt = IF_ST_PEND;
                    w_bubble    = flush;
                end else if (br_taken) begin
                    w_pc_nxt = br_target;
                    w_bubble = 1'b1;
                end else if (flush) begin
                    w_bubble = 1'b1;
                end else if (!stall) begin
                    w_load   = 1'b1;
                    w_pc_nxt = w_pc_plus1;
                end
            end
            IF_ST_PEND: begin
                if (stall) begin
                    if (br_taken) begin
                        w_pend_nxt = br_target;
                    end
                    w_bubble = flush;
                end else begin
                    w_pc_nxt    = br_taken ? br_target : r_pend_target;
                    w_bubble    = 1'b1;
                    w_state_nxt = IF_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = IF_ST_RUN;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_pc     (r_pc),
        .i_npc    (w_pc_plus1),
        .i_inst   (inst),
        .o_pc     (id_pc),
        .o_npc    (id_npc),
        .o_inst   (id_inst),
        .o_valid  (id_valid)
    );

    assign pc = r_pc;

`ifdef IF_FETCH_CNT_EN
    logic [CNT_W-1:0] r_fetch_cnt;

    // Counts every real instruction loaded into IF/ID.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
        end else if (w_load) begin
            r_fetch_cnt <= CNT_W'(r_fetch_cnt + CNT_W'(1));
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`else
    assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [15:0] id_pc;
    logic [15:0] id_npc;
    logic [15:0] id_inst;
    logic        id_valid;
    logic [15:0] fetch_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [15:0] m_pc, m_tgt, m_id_pc, m_id_npc, m_id_inst, m_cnt;
    logic        m_pend, m_id_valid;

    always #5 clk = ~clk;

    if_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .inst      (inst),
        .id_pc     (id_pc),
        .id_npc    (id_npc),
        .id_inst   (id_inst),
        .id_valid  (id_valid),
        .fetch_cnt (fetch_cnt)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h6801;
            16'd1:   return 16'h6902;
            16'd2:   return 16'h6A01;
            default: return (a * 16'd7) ^ 16'h3C00;
        endcase
    endfunction

    always_comb inst = mem_word(pc);

    function automatic logic [80:0] exp_vec();
`ifdef IF_FETCH_CNT_EN
        return {m_pc, m_id_pc, m_id_npc, m_id_inst, m_id_valid, m_cnt};
`else
        return {m_pc, m_id_pc, m_id_npc, m_id_inst, m_id_valid, 16'h0000};
`endif
    endfunction

    wire [80:0] dut_vec = {pc, id_pc, id_npc, id_inst, id_valid, fetch_cnt};

    task automatic bubble_model();
        m_id_pc = 16'h0; m_id_npc = 16'h0; m_id_inst = 16'h0800; m_id_valid = 1'b0;
    endtask

    // Applies one clock edge of the fetch rules to the model.
    task automatic model_step();
        if (!rst) begin
            m_pc = 16'h0; m_pend = 1'b0; m_tgt = 16'h0; m_cnt = 16'h0;
            bubble_model();
        end else if (!m_pend) begin
            if (br_taken && stall) begin
                m_pend = 1'b1; m_tgt = br_target;
                if (flush) bubble_model();
            end else if (br_taken) begin
                m_pc = br_target; bubble_model();
            end else if (flush) begin
                bubble_model();
            end else if (!stall) begin
                m_id_pc = m_pc; m_id_npc = m_pc + 16'd1; m_id_inst = mem_word(m_pc); m_id_valid = 1'b1;
                m_pc = m_pc + 16'd1; m_cnt = m_cnt + 16'd1;
            end
        end else if (stall) begin
            if (br_taken) m_tgt = br_target;
            if (flush) bubble_model();
        end else begin
            m_pc = br_taken ? br_target : m_tgt;
            m_pend = 1'b0;
            bubble_model();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 16'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle_inputs();
        tick(); tick();
        rst = 1'b1;
        n_chk++;
        if ({pc, id_inst, id_pc, id_npc, id_valid} !== {16'h0000, 16'h0800, 16'h0000, 16'h0000, 1'b0}) begin
            $display("FAIL reset_state: got pc=%h inst=%h id_pc=%h npc=%h v=%b exp 0000 0800 0000 0000 0",
                     pc, id_inst, id_pc, id_npc, id_valid);
        end else n_pass++;
        n_chk++;
        if (fetch_cnt !== 16'h0) $display("FAIL reset_cnt: got %h exp 0000", fetch_cnt);
        else n_pass++;
    endtask

    task automatic test_seq();
        logic [15:0] exp_inst [3];
        exp_inst[0] = 16'h6801; exp_inst[1] = 16'h6902; exp_inst[2] = 16'h6A01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_chk++;
            if ({pc, id_inst, id_valid, id_pc} !== {16'(k), exp_inst[k-1], 1'b1, 16'(k-1)}) begin
                $display("FAIL seq_c%0d: got pc=%h inst=%h v=%b id_pc=%h exp pc=%h inst=%h v=1 id_pc=%h",
                         k, pc, id_inst, id_valid, id_pc, 16'(k), exp_inst[k-1], 16'(k-1));
            end else n_pass++;
        end
    endtask

    task automatic test_branch();
        tick(); tick();
        n_chk++;
        if (pc !== 16'h5) $display("FAIL branch_pre pc: got %h exp 0005", pc); else n_pass++;
        br_taken = 1'b1; br_target = 16'h2;
        tick();
        idle_inputs();
        n_chk++;
        if ({pc, id_valid, id_inst} !== {16'h2, 1'b0, 16'h0800})
            $display("FAIL branch_bubble: got pc=%h v=%b inst=%h exp 0002 0 0800", pc, id_valid, id_inst);
        else n_pass++;
        tick();
        n_chk++;
        if ({id_pc, id_valid, id_npc} !== {16'h2, 1'b1, 16'h3})
            $display("FAIL branch_target: got id_pc=%h v=%b npc=%h exp 0002 1 0003", id_pc, id_valid, id_npc);
        else n_pass++;
    endtask

    task automatic test_stall_redirect();
        for (int k = 0; k < 4; k++) tick();
        n_chk++;
        if (pc !== 16'h7) $display("FAIL stall_pre pc: got %h exp 0007", pc); else n_pass++;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            br_taken = (k == 1); br_target = (k == 1) ? 16'h000A : 16'h0;
            tick();
            n_chk++;
            if ({pc, id_pc} !== {16'h7, 16'h6})
                $display("FAIL stall_hold_c%0d: got pc=%h id_pc=%h exp 0007 0006", k, pc, id_pc);
            else n_pass++;
        end
        idle_inputs();
        tick();
        n_chk++;
        if ({pc, id_valid, id_inst} !== {16'h000A, 1'b0, 16'h0800})
            $display("FAIL stall_release: got pc=%h v=%b inst=%h exp 000a 0 0800", pc, id_valid, id_inst);
        else n_pass++;
        tick();
        n_chk++;
        if ({id_pc, id_valid} !== {16'h000A, 1'b1})
            $display("FAIL stall_target: got id_pc=%h v=%b exp 000a 1", id_pc, id_valid);
        else n_pass++;
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_target = 16'hFFFF;
        tick();
        idle_inputs();
        n_chk++;
        if (pc !== 16'hFFFF) $display("FAIL wrap_pre pc: got %h exp ffff", pc); else n_pass++;
        tick();
        n_chk++;
        if ({pc, id_pc, id_npc, id_valid} !== {16'h0000, 16'hFFFF, 16'h0000, 1'b1})
            $display("FAIL wrap: got pc=%h id_pc=%h npc=%h v=%b exp 0000 ffff 0000 1", pc, id_pc, id_npc, id_valid);
        else n_pass++;
        tick();
        n_chk++;
        if ({pc, id_pc, id_inst} !== {16'h0001, 16'h0000, 16'h6801})
            $display("FAIL wrap_next: got pc=%h id_pc=%h inst=%h exp 0001 0000 6801", pc, id_pc, id_inst);
        else n_pass++;
    endtask

    task automatic test_flush();
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        idle_inputs();
        n_chk++;
        if ({pc, id_valid, id_inst, id_pc} !== {16'h4, 1'b0, 16'h0800, 16'h0})
            $display("FAIL flush: got pc=%h v=%b inst=%h id_pc=%h exp 0004 0 0800 0000", pc, id_valid, id_inst, id_pc);
        else n_pass++;
        tick();
        n_chk++;
        if ({id_pc, id_valid, pc} !== {16'h4, 1'b1, 16'h5})
            $display("FAIL flush_refetch: got id_pc=%h v=%b pc=%h exp 0004 1 0005", id_pc, id_valid, pc);
        else n_pass++;
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL directed_model: got %h exp %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_pend();
        stall = 1'b1; br_taken = 1'b1; br_target = 16'h0030;
        tick();
        br_taken = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; idle_inputs();
        n_chk++;
        if ({pc, id_valid, fetch_cnt} !== {16'h0, 1'b0, 16'h0})
            $display("FAIL reset_pend: got pc=%h v=%b cnt=%h exp 0000 0 0000", pc, id_valid, fetch_cnt);
        else n_pass++;
        tick();
        n_chk++;
        if ({pc, id_pc, id_valid} !== {16'h1, 16'h0, 1'b1})
            $display("FAIL reset_pend_run: got pc=%h id_pc=%h v=%b exp 0001 0000 1", pc, id_pc, id_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(99) >= 2);
            stall     = ($urandom_range(99) < 35);
            flush     = ($urandom_range(99) < 10);
            br_taken  = ($urandom_range(99) < 15);
            br_target = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom_range(65535));
            tick();
            n_chk++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_c%0d: got %h exp %h", c, dut_vec, exp_vec());
            else n_pass++;
        end
        idle_inputs(); rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_stall_redirect();
        test_wrap();
        test_flush();
        test_reset_pend();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
